// File: rtl/histogram_acq_ctrl_if.sv
// RAM master port plus readout stream of the histogram acquisition controller.
`timescale 1ns/1ps
interface histogram_acq_ctrl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 16
);
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [CNT_W-1:0]  ram_wdata;
    logic [CNT_W-1:0]  ram_rdata;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_last;

    modport master (
        output ram_en, ram_we, ram_addr, ram_wdata, rd_valid, rd_addr, rd_data, rd_last,
        input  ram_rdata, rd_ready
    );

    modport slave (
        input  ram_en, ram_we, ram_addr, ram_wdata, rd_valid, rd_addr, rd_data, rd_last,
        output ram_rdata, rd_ready
    );
endinterface

// File: rtl/histogram_acq_ctrl.sv
// Acquisition sequencer: clears the histogram RAM, counts bin events by read-modify-write
// for a programmed exposure, then streams every bin out.
`timescale 1ns/1ps
module histogram_acq_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned EXP_W  = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [EXP_W-1:0]     exposure_cycles,
    input  logic                 ev_valid,
    input  logic [ADDR_W-1:0]    ev_addr,
    histogram_acq_ctrl_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          drop_count
);
    typedef enum logic [2:0] {StIdle, StClear, StAcquire, StDrain, StReadout} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              r_valid_q, r_valid_d, w_valid_q, w_valid_d, p_valid_q, p_valid_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d, w_addr_q, w_addr_d, p_addr_q, p_addr_d;
    logic [15:0]       drop_q, drop_d;
    logic              rd_valid_q, rd_valid_d, cap_q, cap_d, ro_first_q, ro_first_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  rd_data_q, rd_data_d;
    logic              done_q, done_d;

    logic              ev_take, eng_idle, slot_rd, rd_now, direct, store, drop;
    logic [ADDR_W-1:0] rmw_addr, ro_addr;
    logic [CNT_W-1:0]  inc_data;
    logic              hs, last_bin, ro_issue;

    // A direct issue needs a fully idle engine; otherwise the slot buffers one event and
    // reads in the first cycle that is neither an R nor a W cycle.
    assign ev_take  = ev_valid && (state_q == StAcquire);
    assign eng_idle = !r_valid_q && !w_valid_q && !p_valid_q;
    assign slot_rd  = p_valid_q && !r_valid_q && !w_valid_q;
    assign rd_now   = r_valid_q || slot_rd;
    assign rmw_addr = r_valid_q ? r_addr_q : p_addr_q;
    assign direct   = ev_take && eng_idle;
    assign store    = ev_take && !eng_idle && (!p_valid_q || slot_rd);
    assign drop     = ev_take && !eng_idle && p_valid_q && !slot_rd;
    assign inc_data = (&bus.ram_rdata) ? bus.ram_rdata : bus.ram_rdata + CNT_W'(1);

    assign hs       = rd_valid_q && bus.rd_ready;
    assign last_bin = &rd_addr_q;
    assign ro_issue = (state_q == StReadout) && (ro_first_q || (hs && !last_bin));
    assign ro_addr  = ro_first_q ? '0 : rd_addr_q + ADDR_W'(1);

    always_comb begin
        state_d    = state_q;
        clr_d      = clr_q;
        exp_d      = exp_q;
        drop_d     = drop_q;
        done_d     = 1'b0;
        ro_first_d = 1'b0;
        r_valid_d  = direct;
        r_addr_d   = ev_addr;
        w_valid_d  = rd_now;
        w_addr_d   = rmw_addr;
        p_valid_d  = store ? 1'b1 : (slot_rd ? 1'b0 : p_valid_q);
        p_addr_d   = store ? ev_addr : p_addr_q;
        rd_valid_d = rd_valid_q;
        rd_addr_d  = rd_addr_q;
        rd_data_d  = rd_data_q;
        cap_d      = ro_issue;

        if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
        if (ro_issue) rd_addr_d = ro_addr;
        if (cap_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = bus.ram_rdata;
        end
        if (hs) rd_valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                    exp_d   = exposure_cycles;
                    drop_d  = '0;
                    clr_d   = '0;
                end
            end
            StClear: begin
                clr_d = clr_q + ADDR_W'(1);
                if (&clr_q) state_d = (exp_q == '0) ? StDrain : StAcquire;
            end
            StAcquire: begin
                exp_d = exp_q - EXP_W'(1);
                if (exp_q == EXP_W'(1)) state_d = StDrain;
            end
            StDrain: begin
                if (eng_idle) begin
                    state_d    = StReadout;
                    ro_first_d = 1'b1;
                end
            end
            StReadout: begin
                if (hs && last_bin) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        case (state_q)
            StClear: begin
                bus.ram_en   = 1'b1;
                bus.ram_we   = 1'b1;
                bus.ram_addr = clr_q;
            end
            StAcquire, StDrain: begin
                if (w_valid_q) begin
                    bus.ram_en    = 1'b1;
                    bus.ram_we    = 1'b1;
                    bus.ram_addr  = w_addr_q;
                    bus.ram_wdata = inc_data;
                end else if (rd_now) begin
                    bus.ram_en   = 1'b1;
                    bus.ram_addr = rmw_addr;
                end
            end
            StReadout: begin
                if (ro_issue) begin
                    bus.ram_en   = 1'b1;
                    bus.ram_addr = ro_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            clr_q      <= '0;
            exp_q      <= '0;
            r_valid_q  <= 1'b0;
            r_addr_q   <= '0;
            w_valid_q  <= 1'b0;
            w_addr_q   <= '0;
            p_valid_q  <= 1'b0;
            p_addr_q   <= '0;
            drop_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            cap_q      <= 1'b0;
            ro_first_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            exp_q      <= exp_d;
            r_valid_q  <= r_valid_d;
            r_addr_q   <= r_addr_d;
            w_valid_q  <= w_valid_d;
            w_addr_q   <= w_addr_d;
            p_valid_q  <= p_valid_d;
            p_addr_q   <= p_addr_d;
            drop_q     <= drop_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            cap_q      <= cap_d;
            ro_first_q <= ro_first_d;
            done_q     <= done_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_last  = rd_valid_q && last_bin;
    assign busy         = (state_q != StIdle);
    assign done         = done_q;
    assign drop_count   = drop_q;
endmodule

// File: tb/tb_histogram_acq_ctrl.sv
// Bench for histogram_acq_ctrl: RAM model, scoreboard of expected bin words, random backpressure.
`timescale 1ns/1ps
module tb_histogram_acq_ctrl;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned EXP_W  = 24;
    localparam int unsigned NBINS  = 256;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  data;
    } word_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [EXP_W-1:0]  exposure_cycles;
    logic              ev_valid;
    logic [ADDR_W-1:0] ev_addr;
    logic              busy;
    logic              done;
    logic [15:0]       drop_count;

    histogram_acq_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    histogram_acq_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .EXP_W(EXP_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .exposure_cycles (exposure_cycles),
        .ev_valid        (ev_valid),
        .ev_addr         (ev_addr),
        .bus             (bus),
        .busy            (busy),
        .done            (done),
        .drop_count      (drop_count)
    );

    always #5 clk = ~clk;

    logic [CNT_W-1:0] mem [NBINS];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    int    n_checks = 0;
    int    n_errors = 0;
    int    hist [NBINS];
    word_t sb_q [$];
    int    hs_cnt = 0;
    bit    bp_en  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        bus.rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.rd_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Readout monitor: pops the scoreboard on every handshake, checks hold during stalls.
    initial begin
        bit                stall_q = 1'b0;
        logic [ADDR_W-1:0] stall_addr = '0;
        logic [CNT_W-1:0]  stall_data = '0;
        word_t             e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    check("hold_valid", 32'(bus.rd_valid), 32'd1);
                    check("hold_addr", 32'(bus.rd_addr), 32'(stall_addr));
                    check("hold_data", 32'(bus.rd_data), 32'(stall_data));
                end
                if (bus.rd_valid && bus.rd_ready) begin
                    hs_cnt++;
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 32'(hs_cnt), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("rd_addr", 32'(bus.rd_addr), 32'(e.addr));
                        check("rd_data", 32'(bus.rd_data), 32'(e.data));
                        check("rd_last", 32'(bus.rd_last), 32'(e.addr == 8'd255));
                    end
                end
                stall_q    = bus.rd_valid && !bus.rd_ready;
                stall_addr = bus.rd_addr;
                stall_data = bus.rd_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first ACQUIRE cycle (or the DRAIN cycle when e == 0).
    task automatic start_run(input int e);
        for (int i = 0; i < 20 && busy; i++) tick();
        check("idle_before_start", 32'(busy), 32'd0);
        for (int i = 0; i < int'(NBINS); i++) hist[i] = 0;
        hs_cnt          = 0;
        exposure_cycles = EXP_W'(e);
        start           = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("clr_we", 32'({bus.ram_en, bus.ram_we}), 32'd3);
        check("clr_addr0", 32'(bus.ram_addr), 32'd0);
        check("clr_wdata", 32'(bus.ram_wdata), 32'd0);
        repeat (NBINS) tick();
    endtask

    task automatic send_ev(input int a);
        ev_valid = 1'b1;
        ev_addr  = ADDR_W'(a);
        tick();
        ev_valid = 1'b0;
    endtask

    task automatic finish_run(input int exp_drop);
        word_t w;
        for (int i = 0; i < int'(NBINS); i++) begin
            w.addr = ADDR_W'(i);
            w.data = CNT_W'(hist[i]);
            sb_q.push_back(w);
        end
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("hs_count", 32'(hs_cnt), 32'(NBINS));
        check("drop_count", 32'(drop_count), 32'(exp_drop));
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("sb_left", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        ev_valid        = 1'b0;
        ev_addr         = '0;
        exposure_cycles = '0;
        repeat (3) tick();
        check("rst_ram", 32'({bus.ram_en, bus.ram_we}), 32'd0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
        check("rst_rd", 32'({bus.rd_valid, bus.rd_last}), 32'd0);
        check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        rst = 1'b0;
        tick();

        // Single bin, with RMW latency check on the first event and an ignored start.
        start_run(100);
        send_ev(5);
        check("rmw_read", 32'({bus.ram_en, bus.ram_we}), 32'd2);
        check("rmw_read_addr", 32'(bus.ram_addr), 32'd5);
        tick();
        check("rmw_write", 32'({bus.ram_en, bus.ram_we}), 32'd3);
        check("rmw_write_addr", 32'(bus.ram_addr), 32'd5);
        check("rmw_wdata", 32'(bus.ram_wdata), 32'd1);
        repeat (2) tick();
        for (int k = 0; k < 2; k++) begin
            send_ev(5);
            repeat (3) tick();
        end
        exposure_cycles = '0;
        start           = 1'b1;
        tick();
        start = 1'b0;
        hist[5] = 3;
        finish_run(0);

        // Back-to-back burst: third event hits a busy engine and a full slot.
        start_run(100);
        ev_valid = 1'b1;
        ev_addr  = 8'd1;
        tick();
        ev_addr = 8'd2;
        tick();
        ev_addr = 8'd3;
        tick();
        ev_valid = 1'b0;
        hist[1] = 1;
        hist[2] = 1;
        finish_run(1);

        // Saturation at 2^CNT_W-1.
        start_run(100);
        for (int k = 0; k < 5; k++) begin
            send_ev(7);
            repeat (3) tick();
        end
        hist[7] = 3;
        finish_run(0);

        // Zero exposure over stale contents: all bins read back 0.
        start_run(0);
        finish_run(0);

        // Sustained one event per 2 cycles, then readout under random backpressure.
        start_run(60);
        for (int k = 0; k < 8; k++) begin
            send_ev(20 + k);
            tick();
            hist[20 + k] = 1;
        end
        bp_en = 1'b1;
        finish_run(0);
        bp_en = 1'b0;

        // Reset during ACQUIRE, events while idle, then a clean run.
        start_run(200);
        send_ev(40);
        repeat (3) tick();
        send_ev(41);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ram_en", 32'(bus.ram_en), 32'd0);
        send_ev(9);
        check("idle_ev_ram_en", 32'(bus.ram_en), 32'd0);
        tick();
        check("idle_ev_ram_en2", 32'(bus.ram_en), 32'd0);
        send_ev(9);
        start_run(40);
        send_ev(9);
        repeat (3) tick();
        send_ev(9);
        hist[9] = 2;
        finish_run(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
